rule_verdict_ctrl: RTL and testbench

RULE_VERDICT_CTRL -- requirements
Module: rule_verdict_ctrl

---
 rtl/rule_verdict_ctrl.sv | 137 +++++++++++++
 tb/tb_rule_verdict_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rule_verdict_ctrl.sv
// Packet verdict controller: sequences the rule decision stage over NUM_PAIRS rule
// pairs and reports accept/drop, the first rejecting rule and timeouts.
module rule_verdict_ctrl #(
    parameter int unsigned NUM_PAIRS = 128,
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pkt_valid,
    output logic             pkt_ready,
    output logic             dl_ena,
    output logic             dl_rst,
    input  logic             dl_ready,
    input  logic             dl_accept1,
    input  logic             dl_accept2,
    output logic             verdict_valid,
    output logic             verdict_accept,
    output logic [7:0]       verdict_rule,
    output logic             verdict_timeout,
    input  logic             verdict_ack,
    output logic [CNT_W-1:0] accept_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {StIdle, StRestart, StScan, StDone} state_e;

    localparam logic [6:0]       LastPair   = 7'(NUM_PAIRS - 1);
    localparam logic [7:0]       TimeoutCnt = 8'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax     = '1;

    state_e           state_q, state_d;
    logic [6:0]       pair_cnt_q, pair_cnt_d;
    logic [7:0]       idle_cnt_q, idle_cnt_d;
    logic [7:0]       rule_q, rule_d;
    logic             acc_q, acc_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] accept_cnt_q, accept_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [7:0]       idle_inc;

    assign idle_inc = idle_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        pair_cnt_d   = pair_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        rule_d       = rule_q;
        acc_d        = acc_q;
        to_d         = to_q;
        accept_cnt_d = accept_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pkt_valid) state_d = StRestart;
            end
            StRestart: begin
                pair_cnt_d = '0;
                idle_cnt_d = '0;
                state_d    = StScan;
            end
            StScan: begin
                if (dl_ready) begin
                    idle_cnt_d = '0;
                    if (dl_accept1 && dl_accept2) begin
                        if (pair_cnt_q == LastPair) begin
                            state_d = StDone;
                            acc_d   = 1'b1;
                            to_d    = 1'b0;
                            rule_d  = '0;
                        end else begin
                            pair_cnt_d = pair_cnt_q + 7'd1;
                        end
                    end else begin
                        // Even rule wins: odd bit is set only when the even rule accepted.
                        state_d = StDone;
                        acc_d   = 1'b0;
                        to_d    = 1'b0;
                        rule_d  = {pair_cnt_q, dl_accept1};
                    end
                end else if (idle_inc == TimeoutCnt) begin
                    state_d    = StDone;
                    idle_cnt_d = idle_inc;
                    acc_d      = 1'b0;
                    to_d       = 1'b1;
                    rule_d     = {pair_cnt_q, 1'b0};
                end else begin
                    idle_cnt_d = idle_inc;
                end
            end
            StDone: begin
                if (verdict_ack) begin
                    state_d = StIdle;
                    if (acc_q) begin
                        if (accept_cnt_q != CntMax) accept_cnt_d = accept_cnt_q + 1'b1;
                    end else begin
                        if (drop_cnt_q != CntMax) drop_cnt_d = drop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pair_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            rule_q       <= '0;
            acc_q        <= 1'b0;
            to_q         <= 1'b0;
            accept_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pair_cnt_q   <= pair_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            rule_q       <= rule_d;
            acc_q        <= acc_d;
            to_q         <= to_d;
            accept_cnt_q <= accept_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign pkt_ready       = (state_q == StIdle);
    assign dl_ena          = (state_q == StScan);
    assign dl_rst          = rst | (state_q == StRestart);
    assign verdict_valid   = (state_q == StDone);
    assign verdict_accept  = (state_q == StDone) & acc_q;
    assign verdict_timeout = (state_q == StDone) & to_q;
    assign verdict_rule    = rule_q;
    assign accept_cnt      = accept_cnt_q;
    assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_rule_verdict_ctrl.sv
// Bench for rule_verdict_ctrl: directed scenarios plus random packets scored against
// a per-packet verdict model and saturating counter model.
module tb_rule_verdict_ctrl;

    localparam int NP    = 4;
    localparam int TO    = 15;
    localparam int CW    = 4;
    localparam int NMAX  = 200;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, pkt_valid, pkt_ready, dl_ena, dl_rst, dl_ready, dl_accept1, dl_accept2;
    logic          verdict_valid, verdict_accept, verdict_timeout, verdict_ack;
    logic [7:0]    verdict_rule;
    logic [CW-1:0] accept_cnt, drop_cnt;

    int  checks = 0;
    int  errors = 0;
    int  exp_acc = 0;
    int  exp_drp = 0;
    bit  stim_rdy [NMAX];
    bit  stim_a1  [NMAX];
    bit  stim_a2  [NMAX];

    always #5 clk = ~clk;

    rule_verdict_ctrl #(.NUM_PAIRS(NP), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .dl_ena(dl_ena), .dl_rst(dl_rst), .dl_ready(dl_ready), .dl_accept1(dl_accept1),
        .dl_accept2(dl_accept2), .verdict_valid(verdict_valid),
        .verdict_accept(verdict_accept), .verdict_rule(verdict_rule),
        .verdict_timeout(verdict_timeout), .verdict_ack(verdict_ack),
        .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
    );

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Verdict for the stimulus list: first rejecting rule, full acceptance, or a gap of TO cycles.
    function automatic void model(output int end_i, output bit acc, output logic [7:0] rule,
                                  output bit tmo);
        int p = 0;
        int gap = 0;
        end_i = -1; acc = 0; rule = 8'd0; tmo = 0;
        for (int i = 0; i < NMAX; i++) begin
            if (stim_rdy[i]) begin
                gap = 0;
                if (stim_a1[i] && stim_a2[i]) begin
                    if (p == NP - 1) begin end_i = i; acc = 1; return; end
                    p++;
                end else begin
                    end_i = i;
                    rule = 8'(2 * p + (stim_a1[i] ? 1 : 0));
                    return;
                end
            end else begin
                gap++;
                if (gap == TO) begin end_i = i; tmo = 1; rule = 8'(2 * p); return; end
            end
        end
    endfunction

    task automatic fill(input int rdy_pct, input int acc_pct);
        for (int i = 0; i < NMAX; i++) begin
            stim_rdy[i] = ($urandom_range(0, 99) < rdy_pct);
            stim_a1[i]  = ($urandom_range(0, 99) < acc_pct);
            stim_a2[i]  = ($urandom_range(0, 99) < acc_pct);
        end
    endtask

    // One packet from IDLE through ack; pv_hold keeps pkt_valid high across DONE and the ack.
    task automatic run_packet(input int hold, input bit residue, input bit pv_hold);
        int         end_i;
        bit         e_acc, e_to;
        logic [7:0] e_rule;
        model(end_i, e_acc, e_rule, e_to);
        checks++;
        if (end_i < 0) begin
            errors++;
            $display("FAIL model_end got %0d exp >=0", end_i);
            return;
        end
        @(negedge clk);
        checks++;
        if (pkt_ready !== 1'b1) begin
            errors++; $display("FAIL idle_ready got %b exp 1", pkt_ready);
        end
        pkt_valid = 1'b1;
        @(negedge clk);
        pkt_valid = 1'b0;
        checks++;
        if ({dl_rst, dl_ena, pkt_ready} !== 3'b100) begin
            errors++; $display("FAIL restart got %b exp 100", {dl_rst, dl_ena, pkt_ready});
        end
        for (int i = 0; i <= end_i; i++) begin
            @(negedge clk);
            checks++;
            if ({dl_ena, pkt_ready, verdict_valid, dl_rst} !== 4'b1000) begin
                errors++;
                $display("FAIL scan_cyc%0d got %b exp 1000", i,
                         {dl_ena, pkt_ready, verdict_valid, dl_rst});
            end
            dl_ready = stim_rdy[i]; dl_accept1 = stim_a1[i]; dl_accept2 = stim_a2[i];
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            checks++;
            if ({verdict_valid, verdict_accept, verdict_timeout, verdict_rule, dl_ena, pkt_ready}
                !== {1'b1, e_acc, e_to, e_rule, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL done_h%0d got v%b a%b t%b r%0d en%b rdy%b exp v1 a%b t%b r%0d en0 rdy0",
                         h, verdict_valid, verdict_accept, verdict_timeout, verdict_rule, dl_ena,
                         pkt_ready, e_acc, e_to, e_rule);
            end
            dl_ready   = residue ? 1'($urandom_range(0, 1)) : 1'b0;
            dl_accept1 = 1'($urandom_range(0, 1));
            dl_accept2 = 1'($urandom_range(0, 1));
            pkt_valid  = pv_hold;
            verdict_ack = (h == hold);
        end
        @(negedge clk);
        verdict_ack = 1'b0;
        dl_ready = 1'b0;
        if (e_acc) exp_acc++; else exp_drp++;
        checks++;
        if ({verdict_valid, verdict_accept, verdict_timeout, pkt_ready, dl_rst, verdict_rule,
             accept_cnt, drop_cnt} !== {4'b0001, 1'b0, e_rule, CW'(sat(exp_acc)), CW'(sat(exp_drp))})
        begin
            errors++;
            $display("FAIL after_ack got v%b a%b t%b rdy%b drst%b r%0d acc%0d drp%0d exp 0001 0 r%0d acc%0d drp%0d",
                     verdict_valid, verdict_accept, verdict_timeout, pkt_ready, dl_rst,
                     verdict_rule, accept_cnt, drop_cnt, e_rule, sat(exp_acc), sat(exp_drp));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({pkt_ready, dl_rst, dl_ena, verdict_valid, verdict_rule, accept_cnt, drop_cnt}
            !== {4'b1100, 8'd0, CW'(0), CW'(0)}) begin
            errors++;
            $display("FAIL reset got rdy%b drst%b en%b v%b r%0d acc%0d drp%0d exp 1100 0 0 0",
                     pkt_ready, dl_rst, dl_ena, verdict_valid, verdict_rule, accept_cnt, drop_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({pkt_ready, dl_rst} !== 2'b10) begin
            errors++; $display("FAIL reset_release got %b exp 10", {pkt_ready, dl_rst});
        end
    endtask

    task automatic test_all_accept();
        for (int i = 0; i < NMAX; i++) begin stim_rdy[i] = 1; stim_a1[i] = 1; stim_a2[i] = 1; end
        run_packet(0, 0, 0);
    endtask

    task automatic test_reject_pair2();
        for (int i = 0; i < NMAX; i++) begin stim_rdy[i] = 1; stim_a1[i] = 1; stim_a2[i] = 1; end
        stim_rdy[1] = 0; stim_rdy[3] = 0;
        stim_a2[4] = 0;
        run_packet(3, 1, 0);
    endtask

    task automatic test_timeout();
        for (int i = 0; i < NMAX; i++) begin stim_rdy[i] = 0; stim_a1[i] = 1; stim_a2[i] = 1; end
        run_packet(1, 1, 0);
    endtask

    task automatic test_ack_hold();
        for (int i = 0; i < NMAX; i++) begin stim_rdy[i] = 1; stim_a1[i] = 1; stim_a2[i] = 1; end
        run_packet(10, 1, 1);
        @(negedge clk);
        pkt_valid = 1'b0;
        checks++;
        if ({dl_rst, pkt_ready} !== 2'b10) begin
            errors++; $display("FAIL ack_then_accept got %b exp 10", {dl_rst, pkt_ready});
        end
        repeat (16) @(negedge clk);
        checks++;
        if ({verdict_valid, verdict_timeout, verdict_accept, verdict_rule} !== {3'b110, 8'd0}) begin
            errors++;
            $display("FAIL held_pkt_timeout got v%b t%b a%b r%0d exp v1 t1 a0 r0",
                     verdict_valid, verdict_timeout, verdict_accept, verdict_rule);
        end
        verdict_ack = 1'b1;
        @(negedge clk);
        verdict_ack = 1'b0;
        exp_drp++;
        checks++;
        if ({pkt_ready, drop_cnt} !== {1'b1, CW'(sat(exp_drp))}) begin
            errors++;
            $display("FAIL held_pkt_drop got rdy%b drp%0d exp rdy1 drp%0d",
                     pkt_ready, drop_cnt, sat(exp_drp));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            fill($urandom_range(3, 95), $urandom_range(70, 98));
            run_packet($urandom_range(0, 3), 1, 0);
        end
    endtask

    task automatic test_rst_mid_scan();
        @(negedge clk);
        pkt_valid = 1'b1;
        @(negedge clk);
        pkt_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            dl_ready = 1'b1; dl_accept1 = 1'b1; dl_accept2 = 1'b1;
        end
        @(negedge clk);
        dl_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({dl_rst, pkt_ready, dl_ena, verdict_valid, accept_cnt, drop_cnt, verdict_rule}
            !== {4'b1100, CW'(0), CW'(0), 8'd0}) begin
            errors++;
            $display("FAIL rst_scan got drst%b rdy%b en%b v%b acc%0d drp%0d r%0d exp 1100 0 0 0",
                     dl_rst, pkt_ready, dl_ena, verdict_valid, accept_cnt, drop_cnt, verdict_rule);
        end
        rst = 1'b0;
        exp_acc = 0;
        exp_drp = 0;
        @(negedge clk);
        checks++;
        if ({pkt_ready, dl_rst, verdict_valid} !== 3'b100) begin
            errors++;
            $display("FAIL rst_release got %b exp 100", {pkt_ready, dl_rst, verdict_valid});
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 17; n++) begin
            for (int i = 0; i < NMAX; i++) begin
                stim_rdy[i] = ($urandom_range(0, 3) != 0); stim_a1[i] = 1; stim_a2[i] = 1;
            end
            run_packet(0, 0, 0);
        end
        checks++;
        if (accept_cnt !== 4'hF) begin
            errors++; $display("FAIL sat_final got %h exp f", accept_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; pkt_valid = 1'b0; dl_ready = 1'b0; dl_accept1 = 1'b0; dl_accept2 = 1'b0;
        verdict_ack = 1'b0;
        test_reset();
        test_all_accept();
        test_reject_pair2();
        test_timeout();
        test_ack_hold();
        test_random();
        test_rst_mid_scan();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
